// File: rtl/datapath_pkg.sv
// Shared types and constants for the datapath control FSM.
package datapath_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_SUM  = 2'b01;
  localparam logic [1:0] OP_SUMC = 2'b10;
  localparam logic [1:0] OP_MAC  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    SUM,
    COUNT,
    DONE
  } state_t;

endpackage

// File: rtl/ctrl_watchdog.sv
// COUNT-state watchdog: counts cycles while run is high, clears otherwise.
// expired flags the cycle whose increment would reach TIMEOUT; no backpressure.
module ctrl_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT) + 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign expired = run && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/datapath_ctrl.sv
// Sequencing FSM for the multiplier/adder/counter datapath; done after ITER+3 (MAC: ITER+4) cycles.
// start is only sampled in IDLE; optional COUNT watchdog under DATAPATH_CTRL_TIMEOUT_EN.
module datapath_ctrl
  import datapath_pkg::*;
#(
  parameter int ITER    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  output logic             multien,
  output logic             sumen,
  output logic             Consten,
  output logic             counten,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] ITER_W = CNT_W'(ITER);

  state_t           state, state_n;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] target;
  logic             hit;
  logic             timeout;

  assign hit = (count == target);

`ifdef DATAPATH_CTRL_TIMEOUT_EN
  ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .run     (state == COUNT),
    .expired (timeout)
  );
`else
  // No watchdog: COUNT waits for the counter indefinitely (TIMEOUT is never negative).
  assign timeout = (TIMEOUT < 0);
`endif

  always_comb begin
    state_n = state;
    multien = 1'b0;
    sumen   = 1'b0;
    Consten = 1'b0;
    counten = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (op == OP_MUL || op == OP_MAC) ? MULT : SUM;
        end
      end
      MULT: begin
        multien = 1'b1;
        state_n = (op_q == OP_MAC) ? SUM : COUNT;
      end
      SUM: begin
        sumen   = 1'b1;
        Consten = (op_q == OP_SUMC) || (op_q == OP_MAC);
        state_n = COUNT;
      end
      COUNT: begin
        counten = !hit;
        if (hit || timeout) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_q   <= OP_MUL;
      target <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      if (state == IDLE && start) begin
        op_q <= op;
      end
      // target wraps modulo 2^CNT_W to follow the datapath counter
      if (state_n == COUNT && state != COUNT) begin
        target <= count + ITER_W;
      end
      if (state_n == IDLE) begin
        err <= 1'b0;
      end else if (state == COUNT && state_n == DONE) begin
        err <= timeout && !hit;
      end
    end
  end

endmodule
